ntt_sampler_packer: RTL and testbench
=====================================

Name: ntt_sampler_packer

Overview:
- Sits directly upstream of the NTT sampler input.
- Accepts the rejection sampler's narrow coefficient stream (IN_LANES coeffs/cycle, per-lane valid mask) and packs it into full OUT_LANES-coefficient memory words.
- Drives the NTT's sampler_valid/sampler_data for exactly one polynomial of NUM_COEFFS coefficients per start, then signals poly_done.

Parameters:
- COEFF_W, 24, coefficient width in bits.
- IN_LANES, 2, coefficients offered per input cycle.
- OUT_LANES, 4, coefficients per output word; output width = OUT_LANES*COEFF_W = 96 = MLDSA_MEM_DATA_WIDTH.
- NUM_COEFFS, 256, coefficients per polynomial; must be a multiple of OUT_LANES.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- zeroize  in  1  synchronous clear of all state and data
- start  in  1  single-cycle pulse, begins a new polynomial
- coeff_valid  in  IN_LANES  per-lane valid mask; lane 0 holds the oldest coefficient
- coeff_data  in  IN_LANES*COEFF_W  lane i at bits [i*COEFF_W +: COEFF_W]
- coeff_ready  out  1  packer accepts the coefficients offered this cycle
- sampler_valid  out  1  packed word valid; the NTT consumes it in the same cycle (no backpressure)
- sampler_data  out  OUT_LANES*COEFF_W  packed word; first coefficient at [COEFF_W-1:0]
- poly_done  out  1  one-cycle pulse with the final word
- busy  out  1  high in PACK
- err  out  1  sticky protocol/range error

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high.
- Reset values: coeff_ready=0, sampler_valid=0, sampler_data=0, poly_done=0, busy=0, err=0.
- Accumulator, fill count (0..OUT_LANES+IN_LANES-1) and coefficient count are all 0 at reset.
- States:
  - IDLE: start -> PACK, clearing accumulator, fill and count.
  - PACK: packs coefficients; moves to IDLE in the cycle the final word is registered.
- coeff_ready = (state==PACK) && (count < NUM_COEFFS). It is a combinational decode of registers only, with no path from coeff_valid.
- Accept: a transfer occurs when coeff_ready && |coeff_valid.
  - k = popcount(coeff_valid), clipped to NUM_COEFFS-count.
  - Lanes beyond the clip are dropped silently.
  - Accepted coefficients are appended to the accumulator in lane order.
- Non-contiguous mask (a valid lane above an invalid lane, e.g. 2'b10): set err.
  - Contiguous lanes from lane 0 up to the first gap are accepted.
  - The remainder of the beat is dropped.
- Emit: when fill+k >= OUT_LANES after an accept, the lowest OUT_LANES entries are registered to sampler_data.
  - sampler_valid=1 for exactly the next cycle.
  - Residual entries shift down and fill = fill+k-OUT_LANES.
  - Latency: accept cycle completing a word -> sampler_valid one cycle later.
  - At most one word is emitted per cycle; this is guaranteed because IN_LANES <= OUT_LANES.
- sampler_data holds its value when sampler_valid=0; it is not cleared.
- count += k per accept. When count reaches NUM_COEFFS the last word is emitted. poly_done is asserted in the same cycle as that sampler_valid, and the state returns to IDLE.
- start while in PACK: restart. Partial word and count are discarded, no word is emitted for the discarded partial, and the state stays in PACK.
- zeroize: highest synchronous priority, above start. All registers return to reset values, including err.
- Reset mid-polynomial: immediate return to IDLE; no sampler_valid and no poly_done.
- err clears only on reset or zeroize.

Optional Feature:
- Macro: NTT_PACKER_RANGE_CHECK_EN.
- Defined: each accepted coefficient is compared against Q=8380417. Any coefficient >= Q sets err and is replaced by 0 in the packed word. Counting and timing are unchanged.
- Undefined: no range comparator; coefficients pass through unmodified. err reflects mask violations only.

Test Plan:
- Full polynomial: start, then 128 beats of mask 2'b11 with values 0..255 -> 64 sampler_valid pulses. Word 0 = {3,2,1,0}. poly_done coincides with the word {255,254,253,252}. coeff_ready falls after beat 128.
- Ragged stream: alternate masks 2'b01/2'b11 (3 coeffs per 2 beats) -> words are gap-free and in order. Exactly 64 words, and sampler_valid is never asserted on two consecutive cycles.
- Overshoot and bad mask:
  - Count=255, offer mask 2'b11 -> one coefficient accepted, the final word is emitted, and the extra lane is dropped.
  - Separately, mask 2'b10 -> err=1 and nothing is accepted.
- Restart and zeroize:
  - start after 10 coefficients -> next word begins with the first post-restart coefficient, and 64 further words follow.
  - zeroize mid-stream -> all outputs 0 and busy=0 on the next cycle.
- Async reset asserted between clock edges mid-polynomial -> outputs reset immediately. After release, no sampler_valid until a new start.
- With NTT_PACKER_RANGE_CHECK_EN: inject coefficient 8380417 at position 5 -> word 1 = {7,6,0,4} and err=1.

Source files
------------

// File: rtl/ntt_sampler_packer.sv
// ntt_sampler_packer: packs the rejection sampler's narrow coefficient stream
// (IN_LANES per beat, per-lane valid mask) into OUT_LANES-wide memory words for
// the NTT sampler input, one polynomial of NUM_COEFFS coefficients per start.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   zeroize               synchronous clear of all state and data (beats start)
//   start                 single-cycle pulse, begins (or restarts) a polynomial
//   coeff_valid/_data     input beat; lane 0 is the oldest coefficient
//   coeff_ready           beat accepted this cycle (decoded from registers only)
//   sampler_valid/_data   packed word, first coefficient in the low bits
//   poly_done             pulses together with the final word
//   busy                  high while packing
//   err                   sticky: non-contiguous mask or (optional) range error
//
// Optional feature: define NTT_PACKER_RANGE_CHECK_EN to zero any accepted
// coefficient >= Q = 8380417 and flag it on err.

module ntt_sampler_packer #(
  parameter int unsigned COEFF_W    = 24,
  parameter int unsigned IN_LANES   = 2,
  parameter int unsigned OUT_LANES  = 4,
  parameter int unsigned NUM_COEFFS = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          zeroize,
  input  logic                          start,
  input  logic [IN_LANES-1:0]           coeff_valid,
  input  logic [IN_LANES*COEFF_W-1:0]   coeff_data,
  output logic                          coeff_ready,
  output logic                          sampler_valid,
  output logic [OUT_LANES*COEFF_W-1:0]  sampler_data,
  output logic                          poly_done,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned ACC_LANES = OUT_LANES + IN_LANES - 1;
  localparam int unsigned ACC_W     = ACC_LANES * COEFF_W;
  localparam int unsigned OUT_W     = OUT_LANES * COEFF_W;
  localparam int unsigned IN_W      = IN_LANES * COEFF_W;
  localparam int unsigned FILL_W    = $clog2(OUT_LANES + IN_LANES);
  localparam int unsigned CNT_W     = $clog2(NUM_COEFFS + 1);
  localparam int unsigned K_W       = $clog2(IN_LANES + 1);

  typedef enum logic [0:0] {IDLE, PACK} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [FILL_W-1:0]  fill_q;
  logic [CNT_W-1:0]   count_q;
  logic               sampler_valid_q;
  logic [OUT_W-1:0]   sampler_data_q;
  logic               poly_done_q;
  logic               err_q;

  logic [K_W-1:0]     run_c;
  logic               gap_c;
  logic               bad_mask_c;
  logic [CNT_W-1:0]   rem_c;
  logic [K_W-1:0]     take_c;
  logic [IN_W-1:0]    lanes_c;
  logic               range_err_c;
  logic [ACC_W-1:0]   work_c;
  logic [ACC_W-1:0]   acc_shift_c;
  logic [FILL_W-1:0]  fill_d;
  logic [CNT_W-1:0]   count_d;
  logic               emit_c;
  logic               last_c;

  assign coeff_ready   = (state_q == PACK) && (count_q < CNT_W'(NUM_COEFFS));
  assign busy          = (state_q == PACK);
  assign sampler_valid = sampler_valid_q;
  assign sampler_data  = sampler_data_q;
  assign poly_done     = poly_done_q;
  assign err           = err_q;

  // Contiguous-prefix length of the mask; any valid lane above a gap is an error.
  always_comb begin
    run_c      = '0;
    gap_c      = 1'b0;
    bad_mask_c = 1'b0;
    for (int i = 0; i < IN_LANES; i++) begin
      if (!coeff_valid[i]) begin
        gap_c = 1'b1;
      end else if (gap_c) begin
        bad_mask_c = 1'b1;
      end else begin
        run_c = run_c + K_W'(1);
      end
    end
  end

  // Number accepted this cycle, clipped to what the polynomial still needs.
  always_comb begin
    rem_c  = CNT_W'(NUM_COEFFS) - count_q;
    take_c = '0;
    if (coeff_ready) begin
      take_c = (CNT_W'(run_c) > rem_c) ? K_W'(rem_c) : run_c;
    end
  end

  // Optional range check on accepted lanes only.
`ifdef NTT_PACKER_RANGE_CHECK_EN
  localparam logic [COEFF_W-1:0] Q_VAL = COEFF_W'(8380417);
  always_comb begin
    lanes_c     = coeff_data;
    range_err_c = 1'b0;
    for (int i = 0; i < IN_LANES; i++) begin
      if ((K_W'(i) < take_c) && (coeff_data[i*COEFF_W +: COEFF_W] >= Q_VAL)) begin
        lanes_c[i*COEFF_W +: COEFF_W] = '0;
        range_err_c                   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    lanes_c     = coeff_data;
    range_err_c = 1'b0;
  end
`endif

  // Append accepted lanes at the current fill point; split off a full word.
  always_comb begin
    work_c = acc_q;
    for (int j = 0; j < ACC_LANES; j++) begin
      for (int i = 0; i < IN_LANES; i++) begin
        if ((K_W'(i) < take_c) && (FILL_W'(j) == fill_q + FILL_W'(i))) begin
          work_c[j*COEFF_W +: COEFF_W] = lanes_c[i*COEFF_W +: COEFF_W];
        end
      end
    end
    acc_shift_c = work_c >> OUT_W;
    fill_d      = fill_q + FILL_W'(take_c);
    count_d     = count_q + CNT_W'(take_c);
    emit_c      = (fill_d >= FILL_W'(OUT_LANES));
    last_c      = (take_c != '0) && (count_d == CNT_W'(NUM_COEFFS));
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      fill_q          <= '0;
      count_q         <= '0;
      sampler_valid_q <= 1'b0;
      sampler_data_q  <= '0;
      poly_done_q     <= 1'b0;
      err_q           <= 1'b0;
    end else if (zeroize) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      fill_q          <= '0;
      count_q         <= '0;
      sampler_valid_q <= 1'b0;
      sampler_data_q  <= '0;
      poly_done_q     <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      sampler_valid_q <= 1'b0;
      poly_done_q     <= 1'b0;
      if (coeff_ready && (bad_mask_c || range_err_c)) begin
        err_q <= 1'b1;
      end
      if (start) begin
        // New or restarted polynomial: any partial word is discarded.
        state_q <= PACK;
        acc_q   <= '0;
        fill_q  <= '0;
        count_q <= '0;
      end else if ((state_q == PACK) && (take_c != '0)) begin
        count_q <= count_d;
        if (emit_c) begin
          sampler_valid_q <= 1'b1;
          sampler_data_q  <= work_c[OUT_W-1:0];
          acc_q           <= acc_shift_c;
          fill_q          <= fill_d - FILL_W'(OUT_LANES);
        end else begin
          acc_q  <= work_c;
          fill_q <= fill_d;
        end
        if (last_c) begin
          poly_done_q <= 1'b1;
          state_q     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_sampler_packer.sv
module tb_ntt_sampler_packer;

  localparam int unsigned NUM_COEFFS = 256;
  localparam int unsigned Q          = 8380417;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        zeroize = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  coeff_valid = '0;
  logic [47:0] coeff_data = '0;
  logic        coeff_ready;
  logic        sampler_valid;
  logic [95:0] sampler_data;
  logic        poly_done;
  logic        busy;
  logic        err;

  ntt_sampler_packer dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start(start),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .sampler_valid(sampler_valid), .sampler_data(sampler_data),
    .poly_done(poly_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: pending coefficients and the words they must form.
  logic [23:0] pend[$];
  logic [95:0] exp_words[$];
  bit          exp_done[$];
  longint      exp_cyc[$];
  int          m_count = 0;
  bit          m_active = 0;
  bit          m_err = 0;

  logic [95:0] obs_words[$];
  bit          obs_done[$];
  longint      obs_cyc[$];
  int          consec = 0;
  int          stray_done = 0;
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (sampler_valid === 1'b1) begin
      obs_words.push_back(sampler_data);
      obs_done.push_back(poly_done === 1'b1);
      obs_cyc.push_back(cyc);
      if (prev_v === 1'b1) consec++;
    end else if (poly_done === 1'b1) begin
      stray_done++;
    end
    prev_v = sampler_valid;
  end

  function automatic logic [23:0] rnd24();
    return 24'($urandom);
  endfunction

  function automatic logic [23:0] rnd_small();
    return 24'($urandom_range(0, 4194303));
  endfunction

  task automatic flush();
    obs_words.delete(); obs_done.delete(); obs_cyc.delete();
    exp_words.delete(); exp_done.delete(); exp_cyc.delete();
    consec = 0; stray_done = 0;
  endtask

  task automatic model_clear();
    pend.delete(); m_count = 0; m_active = 0; m_err = 0;
  endtask

  // Spec-level accept: contiguous prefix, clip to remaining, group into words.
  task automatic model_accept(input logic [1:0] mask, input logic [47:0] d, input longint stamp);
    int m, run, k, rem;
    logic [23:0] c;
    if (!m_active || m_count >= NUM_COEFFS || mask == 2'b00) return;
    m = int'(mask);
    if ((m & (m + 1)) != 0) m_err = 1;
    run = $countones(m & ~(m + 1));
    rem = NUM_COEFFS - m_count;
    k = (run < rem) ? run : rem;
    for (int i = 0; i < k; i++) begin
      c = d[i*24 +: 24];
`ifdef NTT_PACKER_RANGE_CHECK_EN
      if (int'(c) >= Q) begin c = 24'd0; m_err = 1; end
`endif
      pend.push_back(c);
    end
    m_count += k;
    if (pend.size() >= 4) begin
      exp_words.push_back({pend[3], pend[2], pend[1], pend[0]});
      repeat (4) void'(pend.pop_front());
      exp_done.push_back(m_count == NUM_COEFFS);
      exp_cyc.push_back(stamp + 1);
    end
    if (m_count == NUM_COEFFS) m_active = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pend.delete(); m_count = 0; m_active = 1;
  endtask

  task automatic pulse_zeroize();
    zeroize = 1'b1;
    @(posedge clk); #1 zeroize = 1'b0;
    model_clear();
  endtask

  task automatic beat(input logic [1:0] mask, input logic [47:0] d);
    longint stamp;
    coeff_valid = mask; coeff_data = d; stamp = cyc;
    @(posedge clk);
    model_accept(mask, d, stamp);
    #1 coeff_valid = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({coeff_ready, sampler_valid, poly_done, busy, err} !== 5'b0 || sampler_data !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_values: got ready=%b v=%b done=%b busy=%b err=%b data=%h, want all 0",
               coeff_ready, sampler_valid, poly_done, busy, err, sampler_data);
    end
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    idle(2);
  endtask

  task automatic test_full_poly();
    flush();
    pulse_start();
    vectors++;
    if (coeff_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL full_ready_after_start: got ready=%b busy=%b, want 1 1", coeff_ready, busy);
    end
    for (int b = 0; b < 128; b++) beat(2'b11, {24'(2*b+1), 24'(2*b)});
    vectors++;
    if (coeff_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready_after_last: got ready=%b busy=%b, want 0 0", coeff_ready, busy);
    end
    idle(3);
    vectors++;
    if (obs_words.size() != 64 || exp_words.size() != 64) begin
      miscompares++;
      $display("FAIL full_word_count: got %0d (model %0d), want 64", obs_words.size(), exp_words.size());
    end
    if (obs_words.size() > 0) begin
      vectors++;
      if (obs_words[0] !== {24'd3, 24'd2, 24'd1, 24'd0}) begin
        miscompares++;
        $display("FAIL full_word0: got %h, want %h", obs_words[0], {24'd3, 24'd2, 24'd1, 24'd0});
      end
      vectors++;
      if (obs_words[obs_words.size()-1] !== {24'd255, 24'd254, 24'd253, 24'd252} ||
          obs_done[obs_done.size()-1] !== 1'b1) begin
        miscompares++;
        $display("FAIL full_last_word: got %h done=%b, want %h done=1",
                 obs_words[obs_words.size()-1], obs_done[obs_done.size()-1],
                 {24'd255, 24'd254, 24'd253, 24'd252});
      end
    end
    for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++) begin
      vectors++;
      if (obs_words[i] !== exp_words[i] || obs_done[i] !== exp_done[i] || obs_cyc[i] != exp_cyc[i]) begin
        miscompares++;
        $display("FAIL full_word[%0d]: got %h done=%b cyc=%0d, want %h done=%b cyc=%0d",
                 i, obs_words[i], obs_done[i], obs_cyc[i], exp_words[i], exp_done[i], exp_cyc[i]);
      end
    end
    vectors++;
    if (stray_done != 0) begin
      miscompares++;
      $display("FAIL full_stray_done: got %0d, want 0", stray_done);
    end
  endtask

  task automatic test_ragged();
    int b;
    pulse_zeroize();
    flush();
    pulse_start();
    b = 0;
    while (m_active && b < 400) begin
      beat((b % 2 == 0) ? 2'b01 : 2'b11, {rnd24(), rnd24()});
      b++;
    end
    idle(3);
    vectors++;
    if (obs_words.size() != 64 || exp_words.size() != 64) begin
      miscompares++;
      $display("FAIL ragged_word_count: got %0d (model %0d), want 64", obs_words.size(), exp_words.size());
    end
    for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++) begin
      vectors++;
      if (obs_words[i] !== exp_words[i] || obs_done[i] !== exp_done[i] || obs_cyc[i] != exp_cyc[i]) begin
        miscompares++;
        $display("FAIL ragged_word[%0d]: got %h done=%b cyc=%0d, want %h done=%b cyc=%0d",
                 i, obs_words[i], obs_done[i], obs_cyc[i], exp_words[i], exp_done[i], exp_cyc[i]);
      end
    end
    vectors++;
    if (consec != 0) begin
      miscompares++;
      $display("FAIL ragged_back_to_back_valid: got %0d, want 0", consec);
    end
    vectors++;
    if (err !== m_err) begin
      miscompares++;
      $display("FAIL ragged_err: got %b, want %b", err, m_err);
    end
  endtask

  task automatic test_overshoot();
    pulse_zeroize();
    flush();
    pulse_start();
    for (int b = 0; b < 127; b++) beat(2'b11, {rnd24(), rnd24()});
    beat(2'b01, {rnd24(), rnd24()});
    vectors++;
    if (coeff_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL overshoot_ready_at_255: got %b, want 1", coeff_ready);
    end
    beat(2'b11, {rnd24(), rnd24()});
    vectors++;
    if (coeff_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL overshoot_ready_at_256: got %b, want 0", coeff_ready);
    end
    idle(3);
    vectors++;
    if (obs_words.size() != 64 || exp_words.size() != 64 || pend.size() != 0) begin
      miscompares++;
      $display("FAIL overshoot_word_count: got %0d (model %0d, leftover %0d), want 64",
               obs_words.size(), exp_words.size(), pend.size());
    end
    for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++) begin
      vectors++;
      if (obs_words[i] !== exp_words[i] || obs_done[i] !== exp_done[i] || obs_cyc[i] != exp_cyc[i]) begin
        miscompares++;
        $display("FAIL overshoot_word[%0d]: got %h done=%b cyc=%0d, want %h done=%b cyc=%0d",
                 i, obs_words[i], obs_done[i], obs_cyc[i], exp_words[i], exp_done[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_bad_mask();
    pulse_zeroize();
    flush();
    pulse_start();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL badmask_err_before: got %b, want 0", err);
    end
    beat(2'b10, {rnd_small(), rnd_small()});
    vectors++;
    if (err !== 1'b1 || m_count != 0) begin
      miscompares++;
      $display("FAIL badmask_err_set: got err=%b (model count %0d), want err=1 count 0", err, m_count);
    end
    for (int b = 0; b < 128; b++) begin
      if (b == 40) beat(2'b10, {rnd_small(), rnd_small()});
      beat(2'b11, {rnd_small(), rnd_small()});
    end
    idle(3);
    vectors++;
    if (obs_words.size() != 64 || exp_words.size() != 64) begin
      miscompares++;
      $display("FAIL badmask_word_count: got %0d (model %0d), want 64", obs_words.size(), exp_words.size());
    end
    for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++) begin
      vectors++;
      if (obs_words[i] !== exp_words[i] || obs_done[i] !== exp_done[i]) begin
        miscompares++;
        $display("FAIL badmask_word[%0d]: got %h done=%b, want %h done=%b",
                 i, obs_words[i], obs_done[i], exp_words[i], exp_done[i]);
      end
    end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL badmask_err_sticky: got %b, want 1", err);
    end
  endtask

  task automatic test_restart();
    logic [47:0] first;
    pulse_zeroize();
    flush();
    pulse_start();
    for (int b = 0; b < 5; b++) beat(2'b11, {rnd24(), rnd24()});
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || coeff_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_state: got busy=%b ready=%b, want 1 1", busy, coeff_ready);
    end
    first = {rnd_small(), rnd_small()};
    beat(2'b11, first);
    for (int b = 1; b < 128; b++) beat(2'b11, {rnd24(), rnd24()});
    idle(3);
    vectors++;
    if (obs_words.size() != 66 || exp_words.size() != 66) begin
      miscompares++;
      $display("FAIL restart_word_count: got %0d (model %0d), want 66", obs_words.size(), exp_words.size());
    end
    if (obs_words.size() > 2) begin
      vectors++;
      if (obs_words[2][47:0] !== first) begin
        miscompares++;
        $display("FAIL restart_first_word: got %h, want %h", obs_words[2][47:0], first);
      end
    end
    for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++) begin
      vectors++;
      if (obs_words[i] !== exp_words[i] || obs_done[i] !== exp_done[i] || obs_cyc[i] != exp_cyc[i]) begin
        miscompares++;
        $display("FAIL restart_word[%0d]: got %h done=%b cyc=%0d, want %h done=%b cyc=%0d",
                 i, obs_words[i], obs_done[i], obs_cyc[i], exp_words[i], exp_done[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_zeroize();
    pulse_zeroize();
    flush();
    pulse_start();
    beat(2'b10, {rnd24(), rnd24()});
    for (int b = 0; b < 3; b++) beat(2'b11, {rnd24() | 24'h1, rnd24() | 24'h1});
    vectors++;
    if (err !== 1'b1 || obs_words.size() != 1) begin
      miscompares++;
      $display("FAIL zeroize_setup: got err=%b words=%0d, want err=1 words=1", err, obs_words.size());
    end
    pulse_zeroize();
    vectors++;
    if ({coeff_ready, sampler_valid, poly_done, busy, err} !== 5'b0 || sampler_data !== 96'd0) begin
      miscompares++;
      $display("FAIL zeroize_outputs: got ready=%b v=%b done=%b busy=%b err=%b data=%h, want all 0",
               coeff_ready, sampler_valid, poly_done, busy, err, sampler_data);
    end
    flush();
    for (int b = 0; b < 6; b++) beat(2'b11, {rnd24(), rnd24()});
    idle(2);
    vectors++;
    if (obs_words.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zeroize_quiet: got words=%0d busy=%b, want 0 0", obs_words.size(), busy);
    end
  endtask

  task automatic test_async_reset();
    pulse_zeroize();
    flush();
    pulse_start();
    for (int b = 0; b < 6; b++) beat(2'b11, {rnd24() | 24'h1, rnd24()});
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({coeff_ready, sampler_valid, poly_done, busy, err} !== 5'b0 || sampler_data !== 96'd0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got ready=%b v=%b done=%b busy=%b err=%b data=%h, want all 0",
               coeff_ready, sampler_valid, poly_done, busy, err, sampler_data);
    end
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    flush();
    for (int b = 0; b < 10; b++) beat(2'b11, {rnd24(), rnd24()});
    idle(2);
    vectors++;
    if (obs_words.size() != 0 || stray_done != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_quiet: got words=%0d done=%0d busy=%b, want 0 0 0",
               obs_words.size(), stray_done, busy);
    end
  endtask

`ifdef NTT_PACKER_RANGE_CHECK_EN
  task automatic test_range();
    logic [23:0] lo;
    pulse_zeroize();
    flush();
    pulse_start();
    for (int b = 0; b < 128; b++) begin
      lo = 24'(2*b);
      beat(2'b11, {24'(2*b+1 == 5 ? Q : 2*b+1), lo});
    end
    idle(3);
    vectors++;
    if (obs_words.size() < 2 || obs_words[1] !== {24'd7, 24'd6, 24'd0, 24'd4}) begin
      miscompares++;
      $display("FAIL range_word1: got %h (words %0d), want %h",
               (obs_words.size() > 1) ? obs_words[1] : 96'd0, obs_words.size(), {24'd7, 24'd6, 24'd0, 24'd4});
    end
    vectors++;
    if (err !== 1'b1 || m_err !== 1'b1) begin
      miscompares++;
      $display("FAIL range_err: got %b (model %b), want 1", err, m_err);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_poly();
    test_ragged();
    test_overshoot();
    test_bad_mask();
    test_restart();
    test_zeroize();
    test_async_reset();
`ifdef NTT_PACKER_RANGE_CHECK_EN
    test_range();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
